// File: rtl/dp_dtm_pkg.sv
// Shared types and constants for the dp_dtm JTAG debug transport module.
package dp_dtm_pkg;

  typedef enum logic [3:0] {
    TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PADR, EX2DR, UPDR,
    SELIR, CAPIR, SHIR, EX1IR, PAIR, EX2IR, UPIR
  } tap_state_t;

  localparam logic [4:0] IR_IDCODE = 5'h01;
  localparam logic [4:0] IR_DTMCS  = 5'h10;
  localparam logic [4:0] IR_DMI    = 5'h11;
  localparam logic [4:0] IR_BYPASS = 5'h1F;

  typedef enum logic [1:0] {OP_NOP = 2'd0, OP_RD = 2'd1, OP_WR = 2'd2} dmi_op_t;
  typedef enum logic [1:0] {ST_OK = 2'd0, ST_FAIL = 2'd2, ST_BUSY = 2'd3} dmi_stat_t;

  localparam int unsigned DTMCS_ABITS_LSB = 4;
  localparam int unsigned DTMCS_STAT_LSB  = 10;
  localparam int unsigned DTMCS_IDLE_LSB  = 12;
  localparam int unsigned DTMCS_DMIRESET  = 16;
  localparam int unsigned DTMCS_HARDRESET = 17;

endpackage

// File: rtl/dp_dtm_tap_fsm.sv
// IEEE 1149.1 TAP controller: state register plus capture/shift/update strobes.
module dp_dtm_tap_fsm
  import dp_dtm_pkg::*;
(
  input  logic       tck,
  input  logic       trst,
  input  logic       tms,
  output tap_state_t o_state,
  output logic       o_capture_ir,
  output logic       o_shift_ir,
  output logic       o_update_ir,
  output logic       o_capture_dr,
  output logic       o_shift_dr,
  output logic       o_update_dr,
  output logic       o_tlr
);

  tap_state_t r_state;
  tap_state_t w_next;

  always_ff @(posedge tck) begin
    if (trst) r_state <= TLR;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    o_capture_ir = 1'b0;
    o_shift_ir   = 1'b0;
    o_update_ir  = 1'b0;
    o_capture_dr = 1'b0;
    o_shift_dr   = 1'b0;
    o_update_dr  = 1'b0;
    o_tlr        = 1'b0;
    case (r_state)
      TLR:   begin w_next = tms ? TLR   : RTI;   o_tlr = 1'b1; end
      RTI:         w_next = tms ? SELDR : RTI;
      SELDR:       w_next = tms ? SELIR : CAPDR;
      CAPDR: begin w_next = tms ? EX1DR : SHDR;  o_capture_dr = 1'b1; end
      SHDR:  begin w_next = tms ? EX1DR : SHDR;  o_shift_dr   = 1'b1; end
      EX1DR:       w_next = tms ? UPDR  : PADR;
      PADR:        w_next = tms ? EX2DR : PADR;
      EX2DR:       w_next = tms ? UPDR  : SHDR;
      UPDR:  begin w_next = tms ? SELDR : RTI;   o_update_dr  = 1'b1; end
      SELIR:       w_next = tms ? TLR   : CAPIR;
      CAPIR: begin w_next = tms ? EX1IR : SHIR;  o_capture_ir = 1'b1; end
      SHIR:  begin w_next = tms ? EX1IR : SHIR;  o_shift_ir   = 1'b1; end
      EX1IR:       w_next = tms ? UPIR  : PAIR;
      PAIR:        w_next = tms ? EX2IR : PAIR;
      EX2IR:       w_next = tms ? UPIR  : SHIR;
      UPIR:  begin w_next = tms ? SELDR : RTI;   o_update_ir  = 1'b1; end
      default:     w_next = TLR;
    endcase
  end

  assign o_state = r_state;

endmodule

// File: rtl/dp_dtm_hs.sv
// JTAG DTM with IR, IDCODE/DTMCS/DMI/BYPASS DRs and a valid/ready DMI handshake.
// Build option DP_DTM_IDCODE_EN adds the IDCODE register and makes it the IR reset value.
module dp_dtm_hs
  import dp_dtm_pkg::*;
#(
  parameter int unsigned ABITS     = 7,
  parameter int unsigned IR_LEN    = 5,
  parameter logic [31:0] IDCODE_V  = 32'h1000_700F,
  parameter logic [2:0]  IDLE_HINT = 3'd1
) (
  input  logic             tck,
  input  logic             trst,
  input  logic             tms,
  input  logic             tdi,
  output logic             tdo,
  output logic             tdo_oe,
  output logic             dmi_req_valid,
  input  logic             dmi_req_ready,
  output logic [ABITS-1:0] dmi_req_addr,
  output logic [31:0]      dmi_req_data,
  output logic [1:0]       dmi_req_op,
  input  logic             dmi_rsp_valid,
  output logic             dmi_rsp_ready,
  input  logic [31:0]      dmi_rsp_data,
  input  logic [1:0]       dmi_rsp_op
);

  localparam int unsigned DMI_W = ABITS + 34;
`ifdef DP_DTM_IDCODE_EN
  localparam logic [IR_LEN-1:0] IR_RST = IR_LEN'(IR_IDCODE);
`else
  localparam logic [IR_LEN-1:0] IR_RST = '1;
`endif

  typedef enum logic [1:0] {SEL_BYP, SEL_ID, SEL_DTMCS, SEL_DMI} dr_sel_t;

  tap_state_t        w_state;
  logic              w_capture_ir, w_shift_ir, w_update_ir;
  logic              w_capture_dr, w_shift_dr, w_update_dr, w_tlr;
  logic [IR_LEN-1:0] r_ir, r_ir_sh;
  logic [DMI_W-1:0]  r_dr;
  logic              r_busy, r_late, r_req_valid;
  dmi_stat_t         r_sticky;
  logic [31:0]       r_rdata, r_req_data;
  logic [ABITS-1:0]  r_req_addr;
  logic [1:0]        r_req_op;
  dr_sel_t           w_sel;
  logic              w_rsp_take, w_rsp_keep, w_busy_eff;
  dmi_stat_t         w_sticky_eff, w_stat;
  logic [31:0]       w_rdata_eff, w_dtmcs;

  dp_dtm_tap_fsm u_tap (
    .tck          (tck),
    .trst         (trst),
    .tms          (tms),
    .o_state      (w_state),
    .o_capture_ir (w_capture_ir),
    .o_shift_ir   (w_shift_ir),
    .o_update_ir  (w_update_ir),
    .o_capture_dr (w_capture_dr),
    .o_shift_dr   (w_shift_dr),
    .o_update_dr  (w_update_dr),
    .o_tlr        (w_tlr)
  );

  always_comb begin
    w_sel = SEL_BYP;
    if (r_ir == IR_LEN'(IR_DTMCS))    w_sel = SEL_DTMCS;
    else if (r_ir == IR_LEN'(IR_DMI)) w_sel = SEL_DMI;
`ifdef DP_DTM_IDCODE_EN
    else if (r_ir == IR_LEN'(IR_IDCODE)) w_sel = SEL_ID;
`endif
  end

  // A response arriving this cycle is folded in before capture/update look at status.
  assign w_rsp_take  = dmi_rsp_valid && dmi_rsp_ready;
  assign w_rsp_keep  = w_rsp_take && !r_late;
  assign w_busy_eff  = r_busy && !w_rsp_take;
  assign w_rdata_eff = w_rsp_keep ? dmi_rsp_data : r_rdata;

  always_comb begin
    w_sticky_eff = r_sticky;
    if (w_rsp_keep && dmi_rsp_op != 2'd0) w_sticky_eff = ST_FAIL;
    w_stat = w_sticky_eff;
    if (w_sticky_eff == ST_OK && w_busy_eff) w_stat = ST_BUSY;
  end

  assign w_dtmcs = {14'b0, 2'b00, 1'b0, IDLE_HINT, 2'(r_sticky), 6'(ABITS), 4'd1};

  always_ff @(posedge tck) begin
    if (trst) begin
      r_ir        <= IR_RST;
      r_ir_sh     <= '0;
      r_dr        <= '0;
      r_busy      <= 1'b0;
      r_late      <= 1'b0;
      r_sticky    <= ST_OK;
      r_rdata     <= '0;
      r_req_valid <= 1'b0;
      r_req_addr  <= '0;
      r_req_data  <= '0;
      r_req_op    <= '0;
    end else begin
      if (r_req_valid && dmi_req_ready) r_req_valid <= 1'b0;
      if (w_rsp_take) begin
        r_busy <= 1'b0;
        r_late <= 1'b0;
        if (!r_late) begin
          r_rdata <= dmi_rsp_data;
          if (dmi_rsp_op != 2'd0) r_sticky <= ST_FAIL;
        end
      end

      if (w_capture_ir)    r_ir_sh <= IR_LEN'(1);
      else if (w_shift_ir) r_ir_sh <= {tdi, r_ir_sh[IR_LEN-1:1]};
      if (w_update_ir)     r_ir    <= r_ir_sh;

      if (w_capture_dr) begin
        case (w_sel)
          SEL_ID:    r_dr <= DMI_W'(IDCODE_V | 32'd1);
          SEL_DTMCS: r_dr <= DMI_W'(w_dtmcs);
          SEL_DMI: begin
            r_dr <= {r_req_addr, w_rdata_eff, 2'(w_stat)};
            if (w_busy_eff) r_sticky <= ST_BUSY;
          end
          default:   r_dr <= '0;
        endcase
      end else if (w_shift_dr) begin
        case (w_sel)
          SEL_DMI: r_dr       <= {tdi, r_dr[DMI_W-1:1]};
          SEL_BYP: r_dr[0]    <= tdi;
          default: r_dr[31:0] <= {tdi, r_dr[31:1]};
        endcase
      end

      if (w_update_dr && w_sel == SEL_DTMCS) begin
        if (r_dr[DTMCS_DMIRESET]) r_sticky <= ST_OK;
        if (r_dr[DTMCS_HARDRESET]) begin
          r_sticky    <= ST_OK;
          r_req_valid <= 1'b0;
          if (w_busy_eff) begin
            r_busy <= 1'b0;
            if (!r_req_valid || dmi_req_ready) r_late <= 1'b1;
          end
        end
      end else if (w_update_dr && w_sel == SEL_DMI && w_sticky_eff == ST_OK) begin
        if (w_busy_eff) r_sticky <= ST_BUSY;
        else if (r_dr[1:0] == OP_RD || r_dr[1:0] == OP_WR) begin
          r_req_addr  <= r_dr[DMI_W-1:34];
          r_req_data  <= r_dr[33:2];
          r_req_op    <= r_dr[1:0];
          r_req_valid <= 1'b1;
          r_busy      <= 1'b1;
        end
      end

      if (w_tlr) begin
        r_ir     <= IR_RST;
        r_sticky <= ST_OK;
      end
    end
  end

  assign tdo_oe        = (w_state == SHIR) || (w_state == SHDR);
  assign tdo           = tdo_oe & ((w_state == SHIR) ? r_ir_sh[0] : r_dr[0]);
  assign dmi_req_valid = r_req_valid;
  assign dmi_req_addr  = r_req_addr;
  assign dmi_req_data  = r_req_data;
  assign dmi_req_op    = r_req_op;
  // late keeps ready up so the orphaned response after dmihardreset can be drained.
  assign dmi_rsp_ready = r_busy | r_late;

endmodule

// File: tb/tb_dp_dtm_hs.sv
// Self-checking bench for dp_dtm_hs: table-driven register scans plus DMI handshake sequences.
module tb_dp_dtm_hs;

  logic        tck = 1'b0;
  logic        trst, tms, tdi, tdo, tdo_oe;
  logic        dmi_req_valid, dmi_req_ready, dmi_rsp_valid, dmi_rsp_ready;
  logic [6:0]  dmi_req_addr;
  logic [31:0] dmi_req_data, dmi_rsp_data;
  logic [1:0]  dmi_req_op, dmi_rsp_op;

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q[$];
  logic [63:0] req_q[$];

  typedef struct {
    string       name;
    logic [4:0]  ir;
    int          n;
    logic [63:0] din;
    logic [63:0] exp;
  } vec_t;
  vec_t tbl[6];

  dp_dtm_hs #(.ABITS(7), .IR_LEN(5), .IDCODE_V(32'h1000_700F), .IDLE_HINT(3'd1)) dut (
    .tck(tck), .trst(trst), .tms(tms), .tdi(tdi), .tdo(tdo), .tdo_oe(tdo_oe),
    .dmi_req_valid(dmi_req_valid), .dmi_req_ready(dmi_req_ready),
    .dmi_req_addr(dmi_req_addr), .dmi_req_data(dmi_req_data), .dmi_req_op(dmi_req_op),
    .dmi_rsp_valid(dmi_rsp_valid), .dmi_rsp_ready(dmi_rsp_ready),
    .dmi_rsp_data(dmi_rsp_data), .dmi_rsp_op(dmi_rsp_op)
  );

  always #5 tck = ~tck;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic clk(input logic m, input logic d);
    tms = m;
    tdi = d;
    @(posedge tck);
    @(negedge tck);
  endtask

  function automatic logic [63:0] dmi(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op);
    return {23'd0, a, d, op};
  endfunction

  task automatic scan_ir(input logic [4:0] code);
    logic [4:0] cap;
    clk(1'b1, 1'b0); clk(1'b1, 1'b0); clk(1'b0, 1'b0); clk(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cap[i] = tdo;
      clk(i == 4, code[i]);
    end
    clk(1'b1, 1'b0); clk(1'b0, 1'b0);
    chk("ir_capture", 64'(cap), 64'd1);
  endtask

  // Expected capture is queued as the scan is launched and retired once it has shifted out.
  task automatic scan_dr(input string name, input logic [63:0] din, input int n, input logic [63:0] exp);
    logic [63:0] dout;
    exp_q.push_back(exp);
    dout = '0;
    clk(1'b1, 1'b0); clk(1'b0, 1'b0); clk(1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      dout[i] = tdo;
      clk(i == n - 1, din[i]);
    end
    clk(1'b1, 1'b0); clk(1'b0, 1'b0);
    if (exp_q.size() == 0) chk({name, "_sb_empty"}, 64'd1, 64'd0);
    else chk(name, dout, exp_q.pop_front());
  endtask

  task automatic dmi_accept(input string name);
    chk({name, "_valid"}, 64'(dmi_req_valid), 64'd1);
    if (req_q.size() == 0) chk({name, "_sb_empty"}, 64'd1, 64'd0);
    else chk({name, "_payload"}, 64'({dmi_req_addr, dmi_req_data, dmi_req_op}), req_q.pop_front());
    dmi_req_ready = 1'b1;
    clk(1'b0, 1'b0);
    dmi_req_ready = 1'b0;
    chk({name, "_valid_drop"}, 64'(dmi_req_valid), 64'd0);
  endtask

  task automatic dmi_respond(input logic [31:0] d, input logic [1:0] op);
    dmi_rsp_valid = 1'b1;
    dmi_rsp_data  = d;
    dmi_rsp_op    = op;
    clk(1'b0, 1'b0);
    dmi_rsp_valid = 1'b0;
    chk("rsp_ready_after", 64'(dmi_rsp_ready), 64'd0);
  endtask

  initial begin
    trst = 1'b1; tms = 1'b1; tdi = 1'b0;
    dmi_req_ready = 1'b0; dmi_rsp_valid = 1'b0; dmi_rsp_data = '0; dmi_rsp_op = '0;

    tbl[0] = '{"dtmcs", 5'h10, 32, 64'd0, 64'h1071};
`ifdef DP_DTM_IDCODE_EN
    tbl[1] = '{"idcode", 5'h01, 32, 64'd0, 64'h1000_700F};
`else
    tbl[1] = '{"idcode_byp", 5'h01, 8, 64'h3C, 64'h78};
`endif
    tbl[2] = '{"bypass", 5'h1F, 8, 64'hC3, 64'h86};
    tbl[3] = '{"unk05_byp", 5'h05, 8, 64'h81, 64'h02};
    tbl[4] = '{"unk00_byp", 5'h00, 4, 64'hF, 64'hE};
    tbl[5] = '{"dmi_idle", 5'h11, 41, 64'd0, 64'd0};

    @(negedge tck);
    clk(1'b1, 1'b0); clk(1'b1, 1'b0);
    chk("rst_outs", 64'({tdo, tdo_oe, dmi_req_valid, dmi_rsp_ready, dmi_req_addr, dmi_req_data, dmi_req_op}), 64'd0);
    trst = 1'b0;
    clk(1'b0, 1'b0);

`ifdef DP_DTM_IDCODE_EN
    scan_dr("rst_ir_dr", 64'hA5A5_0000, 32, 64'h1000_700F);
`else
    scan_dr("rst_ir_dr", 64'hA5A5_0000, 32, 64'h4B4A_0000);
`endif

    for (int i = 0; i < 6; i++) begin
      scan_ir(tbl[i].ir);
      scan_dr(tbl[i].name, tbl[i].din, tbl[i].n, tbl[i].exp);
    end

    // Write held until ready, then ok response.
    req_q.push_back(64'({7'h10, 32'h1, 2'd2}));
    scan_dr("wr_cap", dmi(7'h10, 32'h1, 2'd2), 41, 64'd0);
    for (int i = 0; i < 3; i++) begin
      chk("wr_hold_valid", 64'({dmi_req_valid, dmi_rsp_ready}), 64'd3);
      clk(1'b0, 1'b0);
    end
    dmi_accept("wr");
    dmi_respond(32'h1234_5678, 2'd0);
    scan_dr("wr_stat_ok", 64'd0, 41, dmi(7'h10, 32'h1234_5678, 2'd0));

    // Read, capture before response -> busy, sticky.
    req_q.push_back(64'({7'h22, 32'h0, 2'd1}));
    scan_dr("rd_cap", dmi(7'h22, 32'h0, 2'd1), 41, dmi(7'h10, 32'h1234_5678, 2'd0));
    dmi_accept("rd");
    scan_dr("rd_busy", 64'd0, 41, dmi(7'h22, 32'h1234_5678, 2'd3));
    scan_dr("rd_sticky", dmi(7'h33, 32'h5, 2'd2), 41, dmi(7'h22, 32'h1234_5678, 2'd3));
    chk("rd_upd_ignored", 64'(dmi_req_valid), 64'd0);
    dmi_respond(32'hCAFE_F00D, 2'd0);
    scan_ir(5'h10);
    scan_dr("dtmcs_busy", 64'h1_0000, 32, 64'h1C71);
    scan_ir(5'h11);
    scan_dr("rd_cleared", 64'd0, 41, dmi(7'h22, 32'hCAFE_F00D, 2'd0));

    // Failed response -> sticky 2 until dmireset.
    req_q.push_back(64'({7'h05, 32'hAAAA_5555, 2'd2}));
    scan_dr("f_cap", dmi(7'h05, 32'hAAAA_5555, 2'd2), 41, dmi(7'h22, 32'hCAFE_F00D, 2'd0));
    dmi_accept("f");
    dmi_respond(32'h0, 2'd2);
    scan_dr("f_stat", dmi(7'h06, 32'h0, 2'd1), 41, dmi(7'h05, 32'h0, 2'd2));
    chk("f_upd_ignored", 64'(dmi_req_valid), 64'd0);
    scan_ir(5'h10);
    scan_dr("dtmcs_fail", 64'd0, 32, 64'h1871);
    scan_dr("dtmcs_fail2", 64'h1_0000, 32, 64'h1871);
    scan_dr("dtmcs_clr", 64'd0, 32, 64'h1071);

    // dmihardreset after acceptance drops the late response.
    scan_ir(5'h11);
    req_q.push_back(64'({7'h07, 32'h11, 2'd2}));
    scan_dr("h_cap", dmi(7'h07, 32'h11, 2'd2), 41, dmi(7'h05, 32'h0, 2'd0));
    dmi_accept("h");
    scan_ir(5'h10);
    scan_dr("h_dtmcs", 64'h2_0000, 32, 64'h1071);
    chk("h_valid", 64'(dmi_req_valid), 64'd0);
    dmi_respond(32'h0000_DEAD, 2'd0);
    scan_ir(5'h11);
    scan_dr("h_dropped", 64'd0, 41, dmi(7'h07, 32'h0, 2'd0));

    // Five tms=1 from Shift-DR reach Test-Logic-Reset.
    scan_ir(5'h10);
    clk(1'b1, 1'b0); clk(1'b0, 1'b0); clk(1'b0, 1'b0);
    chk("shdr_oe", 64'(tdo_oe), 64'd1);
    repeat (5) clk(1'b1, 1'b0);
    chk("tlr_oe", 64'(tdo_oe), 64'd0);
    clk(1'b0, 1'b0);
`ifdef DP_DTM_IDCODE_EN
    scan_dr("tlr_ir", 64'hA5A5_0000, 32, 64'h1000_700F);
`else
    scan_dr("tlr_ir", 64'hA5A5_0000, 32, 64'h4B4A_0000);
`endif

    // trst mid-transaction drops valid; the later response is not accepted.
    scan_ir(5'h11);
    scan_dr("t_cap", dmi(7'h01, 32'h2, 2'd2), 41, dmi(7'h07, 32'h0, 2'd0));
    chk("t_valid", 64'(dmi_req_valid), 64'd1);
    trst = 1'b1;
    clk(1'b0, 1'b0);
    trst = 1'b0;
    chk("t_rst_outs", 64'({dmi_req_valid, dmi_rsp_ready, dmi_req_addr}), 64'd0);
    dmi_respond(32'h5555_AAAA, 2'd2);
    clk(1'b0, 1'b0);
    scan_ir(5'h11);
    scan_dr("t_after", 64'd0, 41, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
